// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared mode type, default primitive tap masks and a bit-reverse helper
// for the parametrised LFSR generator.
`default_nettype none

package lfsr_pkg;

  typedef enum logic {
    LFSR_FIB = 1'b0,
    LFSR_GAL = 1'b1
  } lfsr_mode_t;

  // Fibonacci-form primitive tap masks; the top bit is always the state MSB.
  localparam logic [3:0]  LFSR_TAPS_4  = 4'hC;
  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

  function automatic logic [31:0] lfsr_bit_reverse(input logic [31:0] v, input int w);
    logic [31:0] r;
    int          j;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) begin
        j = w - 1 - i;
        r[i[4:0]] = v[j[4:0]];
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_step.sv
// lfsr_step: one combinational LFSR shift in either Fibonacci or Galois form,
// both derived from the same Fibonacci tap mask.
`default_nettype none

module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_state,
  input  lfsr_mode_t       i_mode,
  input  logic [WIDTH-1:0] i_taps,
  output logic [WIDTH-1:0] o_next
);

  logic [WIDTH-1:0] w_gal_taps;
  logic [WIDTH-1:0] w_fib;
  logic [WIDTH-1:0] w_gal;

  // The Galois feedback mask is the Fibonacci mask mirrored, giving the same period.
  assign w_gal_taps = WIDTH'(lfsr_bit_reverse(32'(i_taps), WIDTH));

  assign w_fib  = {i_state[WIDTH-2:0], ^(i_state & i_taps)};
  assign w_gal  = {i_state[WIDTH-2:0], 1'b0} ^ (i_state[WIDTH-1] ? w_gal_taps : '0);
  assign o_next = (i_mode == LFSR_GAL) ? w_gal : w_fib;

endmodule

`default_nettype wire

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised LFSR word source with seed load and valid/ready output.
// Optional macro LFSR_WRAP_EN adds a registered wrap pulse when the state returns to the seed.
`default_nettype none

module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_16),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter int               STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             zero_seed,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] c_SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

  logic [WIDTH-1:0] r_state;
  logic             r_valid;
  logic             r_zero_seed;
  logic             w_adv;
  logic             w_load_zero;
  logic [WIDTH-1:0] w_load_val;
  lfsr_mode_t       w_mode;
  logic [WIDTH-1:0] w_chain [STEP+1];

  assign w_mode      = lfsr_mode_t'(mode);
  assign w_adv       = r_valid & out_ready;
  assign w_load_zero = (load_data == '0);
  assign w_load_val  = w_load_zero ? c_SEED_EFF : load_data;
  assign w_chain[0]  = r_state;

  for (genvar gi = 0; gi < STEP; gi++) begin : g_step
    lfsr_step #(
      .WIDTH (WIDTH)
    ) u_step (
      .i_state (w_chain[gi]),
      .i_mode  (w_mode),
      .i_taps  (TAPS),
      .o_next  (w_chain[gi+1])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= c_SEED_EFF;
      r_valid     <= 1'b0;
      r_zero_seed <= 1'b0;
    end else begin
      r_zero_seed <= 1'b0;
      if (load_valid) begin
        // A load overrides any handshake in the same cycle.
        r_state     <= w_load_val;
        r_valid     <= en;
        r_zero_seed <= w_load_zero;
      end else begin
        if (w_adv) begin
          r_state <= w_chain[STEP];
        end
        r_valid <= en | (r_valid & ~out_ready);
      end
    end
  end

`ifdef LFSR_WRAP_EN
  logic [WIDTH-1:0] r_seed;
  logic             r_wrap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seed <= c_SEED_EFF;
      r_wrap <= 1'b0;
    end else begin
      if (load_valid) begin
        r_seed <= w_load_val;
        r_wrap <= 1'b0;
      end else begin
        r_wrap <= w_adv && (w_chain[STEP] == r_seed);
      end
    end
  end

  assign wrap = r_wrap;
`else
  // Without the comparator nothing reads the seed copy, so it is not built.
  assign wrap = 1'b0;
`endif

  assign out_data  = r_state;
  assign out_valid = r_valid;
  assign zero_seed = r_zero_seed;

endmodule

`default_nettype wire
